// File: rtl/dcache_store_port_pkg.sv
// Shared types and constants for the dcache store port: FSM state encoding,
// memory access type codes and the store buffer pointer width.
package dcache_store_port_pkg;

    localparam int SB_PTR_W = 3;

    localparam logic [1:0] MAT_SUC = 2'b00;
    localparam logic [1:0] MAT_CC  = 2'b01;
    localparam logic [1:0] MAT_WUC = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOOKUP   = 4'd1,
        ST_COMPARE  = 4'd2,
        ST_WRITE    = 4'd3,
        ST_MISSREQ  = 4'd4,
        ST_MISSWAIT = 4'd5,
        ST_UNCREQ   = 4'd6,
        ST_UNCWAIT  = 4'd7,
        ST_DONE     = 4'd8
    } sp_state_e;

    // Only coherent-cached goes through the tag array; 2'b11 falls to the uncached path.
    function automatic logic is_cached(input logic [1:0] mat);
        return mat == MAT_CC;
    endfunction

endpackage

// File: rtl/dcache_store_port_if.sv
// Bundle of every store-port signal: store buffer drain, tag lookup, data write,
// refill request and uncached write bus. slave = the store port, master = its environment.
interface dcache_store_port_if #(
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4,
    parameter int WAY_NUM  = 2
);
    import dcache_store_port_pkg::*;

    localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
    localparam int WAY_W  = $clog2(WAY_NUM);
    localparam int WORD_W = OFFSET_W - 2;

    logic                SbToDcdAble;
    logic [1:0]          SbToDcdAMat;
    logic [SB_PTR_W-1:0] SbToDcdAPtr;
    logic [31:0]         SbToDcdAPhyAddr;
    logic [31:0]         SbToDcdAPhyDate;
    logic [3:0]          SbToDcdAByteEn;
    logic                DcdToSbSuccess;
    logic                DcdToSbBackAble;
    logic [SB_PTR_W-1:0] DcdToSbBackPtr;

    logic                TagRdEn;
    logic [INDEX_W-1:0]  TagRdIndex;
    logic [TAG_W-1:0]    TagRdTag;
    logic                TagHit;
    logic [WAY_W-1:0]    TagHitWay;

    logic                DataWrEn;
    logic [INDEX_W-1:0]  DataWrIndex;
    logic [WAY_W-1:0]    DataWrWay;
    logic [WORD_W-1:0]   DataWrWord;
    logic [3:0]          DataWrByteEn;
    logic [31:0]         DataWrData;

    logic                MissReq;
    logic [31:0]         MissAddr;
    logic                MissAck;
    logic                MissDone;

    logic                UncWrReq;
    logic [31:0]         UncWrAddr;
    logic [31:0]         UncWrData;
    logic [3:0]          UncWrStrb;
    logic                UncWrReady;
    logic                UncWrResp;

    logic                StorePortBusy;
    logic [31:0]         StorePortAddr;

    modport slave (
        input  SbToDcdAble, SbToDcdAMat, SbToDcdAPtr, SbToDcdAPhyAddr,
               SbToDcdAPhyDate, SbToDcdAByteEn,
        output DcdToSbSuccess, DcdToSbBackAble, DcdToSbBackPtr,
        output TagRdEn, TagRdIndex, TagRdTag,
        input  TagHit, TagHitWay,
        output DataWrEn, DataWrIndex, DataWrWay, DataWrWord, DataWrByteEn, DataWrData,
        output MissReq, MissAddr,
        input  MissAck, MissDone,
        output UncWrReq, UncWrAddr, UncWrData, UncWrStrb,
        input  UncWrReady, UncWrResp,
        output StorePortBusy, StorePortAddr
    );

    modport master (
        output SbToDcdAble, SbToDcdAMat, SbToDcdAPtr, SbToDcdAPhyAddr,
               SbToDcdAPhyDate, SbToDcdAByteEn,
        input  DcdToSbSuccess, DcdToSbBackAble, DcdToSbBackPtr,
        input  TagRdEn, TagRdIndex, TagRdTag,
        output TagHit, TagHitWay,
        input  DataWrEn, DataWrIndex, DataWrWay, DataWrWord, DataWrByteEn, DataWrData,
        input  MissReq, MissAddr,
        output MissAck, MissDone,
        input  UncWrReq, UncWrAddr, UncWrData, UncWrStrb,
        output UncWrReady, UncWrResp,
        input  StorePortBusy, StorePortAddr
    );

endinterface

// File: rtl/dcache_store_port.sv
// Dcache-side consumer of the store buffer drain: one store at a time, cached stores
// via lookup/write (refill + replay on miss), uncached stores via a single bus write.
module dcache_store_port
    import dcache_store_port_pkg::*;
#(
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4,
    parameter int WAY_NUM  = 2
) (
    input  logic               Clk,
    input  logic               Rest,
    dcache_store_port_if.slave sp
);

    localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
    localparam int WAY_W  = $clog2(WAY_NUM);
    localparam int WORD_W = OFFSET_W - 2;

    sp_state_e           state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [3:0]          be_q, be_d;
    logic [SB_PTR_W-1:0] ptr_q, ptr_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic                accept;

    logic                back_able_q;
    logic [SB_PTR_W-1:0] back_ptr_q;
    logic                tag_rd_en_q;
    logic [INDEX_W-1:0]  tag_rd_index_q;
    logic [TAG_W-1:0]    tag_rd_tag_q;
    logic                data_wr_en_q;
    logic [INDEX_W-1:0]  data_wr_index_q;
    logic [WAY_W-1:0]    data_wr_way_q;
    logic [WORD_W-1:0]   data_wr_word_q;
    logic [3:0]          data_wr_be_q;
    logic [31:0]         data_wr_data_q;
    logic                miss_req_q;
    logic [31:0]         miss_addr_q;
    logic                unc_wr_req_q;
    logic [31:0]         unc_wr_addr_q;
    logic [31:0]         unc_wr_data_q;
    logic [3:0]          unc_wr_strb_q;
    logic                busy_q;
    logic [31:0]         busy_addr_q;

    // The acknowledge is the only combinational output: same-cycle handshake with the buffer.
    assign accept            = (state_q == ST_IDLE) && sp.SbToDcdAble;
    assign sp.DcdToSbSuccess = accept;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (sp.SbToDcdAble)
                             state_d = is_cached(sp.SbToDcdAMat) ? ST_LOOKUP : ST_UNCREQ;
            ST_LOOKUP:   state_d = ST_COMPARE;
            ST_COMPARE:  state_d = sp.TagHit ? ST_WRITE : ST_MISSREQ;
            ST_WRITE:    state_d = ST_DONE;
            ST_MISSREQ:  if (sp.MissAck)    state_d = ST_MISSWAIT;
            ST_MISSWAIT: if (sp.MissDone)   state_d = ST_LOOKUP;
            ST_UNCREQ:   if (sp.UncWrReady) state_d = ST_UNCWAIT;
            ST_UNCWAIT:  if (sp.UncWrResp)  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // MAT only picks the path out of IDLE, so the state itself carries it afterwards.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        be_d   = be_q;
        ptr_d  = ptr_q;
        way_d  = way_q;
        if (accept) begin
            addr_d = sp.SbToDcdAPhyAddr;
            data_d = sp.SbToDcdAPhyDate;
            be_d   = sp.SbToDcdAByteEn;
            ptr_d  = sp.SbToDcdAPtr;
        end
        if ((state_q == ST_COMPARE) && sp.TagHit) begin
            way_d = sp.TagHitWay;
        end
    end

    // Outputs are decoded from the next state so each strobe lines up with its state.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            data_q          <= '0;
            be_q            <= '0;
            ptr_q           <= '0;
            way_q           <= '0;
            back_able_q     <= 1'b0;
            back_ptr_q      <= '0;
            tag_rd_en_q     <= 1'b0;
            tag_rd_index_q  <= '0;
            tag_rd_tag_q    <= '0;
            data_wr_en_q    <= 1'b0;
            data_wr_index_q <= '0;
            data_wr_way_q   <= '0;
            data_wr_word_q  <= '0;
            data_wr_be_q    <= '0;
            data_wr_data_q  <= '0;
            miss_req_q      <= 1'b0;
            miss_addr_q     <= '0;
            unc_wr_req_q    <= 1'b0;
            unc_wr_addr_q   <= '0;
            unc_wr_data_q   <= '0;
            unc_wr_strb_q   <= '0;
            busy_q          <= 1'b0;
            busy_addr_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            ptr_q   <= ptr_d;
            way_q   <= way_d;

            back_able_q <= (state_d == ST_DONE);
            back_ptr_q  <= (state_d == ST_DONE) ? ptr_d : '0;

            tag_rd_en_q    <= (state_d == ST_LOOKUP);
            tag_rd_index_q <= (state_d == ST_LOOKUP) ? addr_d[OFFSET_W+INDEX_W-1:OFFSET_W] : '0;
            tag_rd_tag_q   <= (state_d == ST_LOOKUP) ? addr_d[31:OFFSET_W+INDEX_W] : '0;

            data_wr_en_q    <= (state_d == ST_WRITE);
            data_wr_index_q <= (state_d == ST_WRITE) ? addr_d[OFFSET_W+INDEX_W-1:OFFSET_W] : '0;
            data_wr_way_q   <= (state_d == ST_WRITE) ? way_d : '0;
            data_wr_word_q  <= (state_d == ST_WRITE) ? addr_d[OFFSET_W-1:2] : '0;
            data_wr_be_q    <= (state_d == ST_WRITE) ? be_d : '0;
            data_wr_data_q  <= (state_d == ST_WRITE) ? data_d : '0;

            miss_req_q  <= (state_d == ST_MISSREQ);
            miss_addr_q <= (state_d == ST_MISSREQ) ?
                           {addr_d[31:OFFSET_W], {OFFSET_W{1'b0}}} : '0;

            unc_wr_req_q  <= (state_d == ST_UNCREQ);
            unc_wr_addr_q <= (state_d == ST_UNCREQ) ? addr_d : '0;
            unc_wr_data_q <= (state_d == ST_UNCREQ) ? data_d : '0;
            unc_wr_strb_q <= (state_d == ST_UNCREQ) ? be_d : '0;

            busy_q      <= (state_d != ST_IDLE);
            busy_addr_q <= (state_d != ST_IDLE) ? addr_d : '0;
        end
    end

    assign sp.DcdToSbBackAble = back_able_q;
    assign sp.DcdToSbBackPtr  = back_ptr_q;
    assign sp.TagRdEn         = tag_rd_en_q;
    assign sp.TagRdIndex      = tag_rd_index_q;
    assign sp.TagRdTag        = tag_rd_tag_q;
    assign sp.DataWrEn        = data_wr_en_q;
    assign sp.DataWrIndex     = data_wr_index_q;
    assign sp.DataWrWay       = data_wr_way_q;
    assign sp.DataWrWord      = data_wr_word_q;
    assign sp.DataWrByteEn    = data_wr_be_q;
    assign sp.DataWrData      = data_wr_data_q;
    assign sp.MissReq         = miss_req_q;
    assign sp.MissAddr        = miss_addr_q;
    assign sp.UncWrReq        = unc_wr_req_q;
    assign sp.UncWrAddr       = unc_wr_addr_q;
    assign sp.UncWrData       = unc_wr_data_q;
    assign sp.UncWrStrb       = unc_wr_strb_q;
    assign sp.StorePortBusy   = busy_q;
    assign sp.StorePortAddr   = busy_addr_q;

endmodule

// File: tb/tb_dcache_store_port.sv
// Self-checking bench for dcache_store_port: directed and random stores against
// responders with random latencies, checked against expectations derived per store.
module tb_dcache_store_port;
    import dcache_store_port_pkg::*;

    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 4;
    localparam int WAY_NUM  = 2;
    localparam int WAY_W    = $clog2(WAY_NUM);

    logic Clk  = 1'b0;
    logic Rest = 1'b1;
    int   cyc  = 0;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    dcache_store_port_if #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .WAY_NUM(WAY_NUM)) bus ();

    dcache_store_port #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .WAY_NUM(WAY_NUM)) dut (
        .Clk  (Clk),
        .Rest (Rest),
        .sp   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic all_outs_zero();
        return !(|{bus.DcdToSbSuccess, bus.DcdToSbBackAble, bus.DcdToSbBackPtr,
                   bus.TagRdEn, bus.TagRdIndex, bus.TagRdTag,
                   bus.DataWrEn, bus.DataWrIndex, bus.DataWrWay, bus.DataWrWord,
                   bus.DataWrByteEn, bus.DataWrData, bus.MissReq, bus.MissAddr,
                   bus.UncWrReq, bus.UncWrAddr, bus.UncWrData, bus.UncWrStrb,
                   bus.StorePortBusy, bus.StorePortAddr});
    endfunction

    // One store from request to completion; the environment answers with the given latencies.
    task automatic run_store(input logic [1:0] mat, input logic [2:0] ptr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be, input int nmiss,
                             input int way, input int ack_dly, input int done_dly,
                             input int rdy_dly, input int resp_dly, input bit keep_able,
                             input logic [2:0] next_ptr, input bit expect_immediate);
        bit cached, tag_prev, drop_able, exp_busy;
        int t0, t_succ, t_tag, t_wr, t_back, t_unc, done_at, resp_at;
        int n_succ, n_tag, n_wr, n_back, n_miss, n_unc, lookups, req_cnt;
        int bad_busy, bad_tag, bad_maddr, bad_unc;
        logic [2:0]  back_ptr;
        logic [31:0] wr_idx, wr_way, wr_word, wr_be, wr_data;
        cached = (mat == MAT_CC);
        tag_prev = 0; drop_able = 0;
        t_succ = -1; t_tag = -1; t_wr = -1; t_back = -1; t_unc = -1; done_at = -1; resp_at = -1;
        n_succ = 0; n_tag = 0; n_wr = 0; n_back = 0; n_miss = 0; n_unc = 0; lookups = 0; req_cnt = 0;
        bad_busy = 0; bad_tag = 0; bad_maddr = 0; bad_unc = 0;
        back_ptr = '0; wr_idx = '0; wr_way = '0; wr_word = '0; wr_be = '0; wr_data = '0;

        @(negedge Clk);
        bus.SbToDcdAble = 1'b1; bus.SbToDcdAMat = mat; bus.SbToDcdAPtr = ptr;
        bus.SbToDcdAPhyAddr = addr; bus.SbToDcdAPhyDate = data; bus.SbToDcdAByteEn = be;
        t0 = cyc;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) @(negedge Clk);
            if (drop_able) begin
                if (keep_able) bus.SbToDcdAPtr = next_ptr;
                else           bus.SbToDcdAble = 1'b0;
                drop_able = 0;
            end
            bus.TagHit     = tag_prev ? (lookups > nmiss) : 1'($urandom_range(0, 1));
            bus.TagHitWay  = tag_prev ? WAY_W'(way) : WAY_W'($urandom_range(0, 1));
            bus.MissDone   = (cyc == done_at);
            bus.UncWrResp  = (cyc == resp_at);
            bus.MissAck    = 1'b0;
            bus.UncWrReady = 1'b0;
            #1;
            if (bus.DcdToSbSuccess && t_back < 0) begin
                n_succ++;
                if (t_succ < 0) t_succ = cyc;
                drop_able = 1;
            end
            if (bus.DcdToSbSuccess && bus.StorePortBusy) bad_busy++;
            if (bus.TagRdEn) begin
                n_tag++; lookups++;
                if (t_tag < 0) t_tag = cyc;
                if (bus.TagRdIndex !== addr[OFFSET_W+INDEX_W-1:OFFSET_W] ||
                    bus.TagRdTag !== addr[31:OFFSET_W+INDEX_W]) bad_tag++;
            end
            tag_prev = bus.TagRdEn;
            if (bus.DataWrEn) begin
                n_wr++; t_wr = cyc;
                wr_idx = 32'(bus.DataWrIndex); wr_way = 32'(bus.DataWrWay);
                wr_word = 32'(bus.DataWrWord); wr_be = 32'(bus.DataWrByteEn); wr_data = bus.DataWrData;
            end
            if (bus.MissReq) begin
                if (bus.MissAddr !== {addr[31:OFFSET_W], 4'b0000}) bad_maddr++;
                if (req_cnt >= ack_dly) begin
                    bus.MissAck = 1'b1; n_miss++; done_at = cyc + done_dly; req_cnt = 0;
                end else req_cnt++;
            end
            if (bus.UncWrReq) begin
                if (t_unc < 0) t_unc = cyc;
                if (bus.UncWrAddr !== addr || bus.UncWrData !== data || bus.UncWrStrb !== be) bad_unc++;
                if (req_cnt >= rdy_dly) begin
                    bus.UncWrReady = 1'b1; n_unc++; resp_at = cyc + resp_dly; req_cnt = 0;
                end else req_cnt++;
            end
            if (bus.DcdToSbBackAble) begin
                n_back++;
                if (t_back < 0) begin t_back = cyc; back_ptr = bus.DcdToSbBackPtr; end
            end
            exp_busy = (t_succ >= 0) && (cyc > t_succ) && ((t_back < 0) || (cyc <= t_back));
            if (bus.StorePortBusy !== exp_busy ||
                bus.StorePortAddr !== (exp_busy ? addr : 32'h0)) bad_busy++;
            if (t_back >= 0 && (keep_able || cyc > t_back)) break;
        end
        bus.MissAck = 1'b0; bus.UncWrReady = 1'b0;

        check_eq("completed", 32'(t_back >= 0), 1);
        check_eq("success_count", n_succ, 1);
        check_eq("back_count", n_back, 1);
        check_eq("back_ptr", 32'(back_ptr), 32'(ptr));
        check_eq("busy_hazard", bad_busy, 0);
        if (expect_immediate) check_eq("b2b_success_cycle", t_succ, t0);
        if (cached) begin
            check_eq("lookups", n_tag, nmiss + 1);
            check_eq("tag_fields", bad_tag, 0);
            check_eq("miss_reqs", n_miss, nmiss);
            check_eq("miss_addr", bad_maddr, 0);
            check_eq("data_writes", n_wr, 1);
            check_eq("wr_index", wr_idx, 32'(addr[OFFSET_W+INDEX_W-1:OFFSET_W]));
            check_eq("wr_way", wr_way, 32'(way));
            check_eq("wr_word", wr_word, 32'(addr[OFFSET_W-1:2]));
            check_eq("wr_be", wr_be, 32'(be));
            check_eq("wr_data", wr_data, data);
            check_eq("unc_writes", n_unc, 0);
            check_eq("back_after_write", t_back, t_wr + 1);
            if (nmiss == 0) begin
                check_eq("hit_tag_cycle", t_tag, t_succ + 1);
                check_eq("hit_write_cycle", t_wr, t_succ + 3);
            end else begin
                check_eq("replay_back_cycle", t_back, done_at + 4);
            end
        end else begin
            check_eq("unc_writes", n_unc, 1);
            check_eq("unc_fields_stable", bad_unc, 0);
            check_eq("unc_req_cycle", t_unc, t_succ + 1);
            check_eq("unc_back_cycle", t_back, resp_at + 1);
            check_eq("lookups", n_tag, 0);
            check_eq("data_writes", n_wr, 0);
        end
        $display("store mat=%0d ptr=%0d addr=0x%08h be=0x%0h miss=%0d acc@%0d back@%0d",
                 mat, ptr, addr, be, nmiss, t_succ, t_back);
    endtask

    initial begin
        int nback;
        bus.SbToDcdAble = 0; bus.SbToDcdAMat = 0; bus.SbToDcdAPtr = 0;
        bus.SbToDcdAPhyAddr = 0; bus.SbToDcdAPhyDate = 0; bus.SbToDcdAByteEn = 0;
        bus.TagHit = 0; bus.TagHitWay = 0; bus.MissAck = 0; bus.MissDone = 0;
        bus.UncWrReady = 0; bus.UncWrResp = 0;

        repeat (3) @(negedge Clk);
        #1 check_eq("reset_outs_zero", 32'(all_outs_zero()), 1);
        @(negedge Clk);
        Rest = 1'b0;
        #1 check_eq("idle_outs_zero", 32'(all_outs_zero()), 1);

        // Directed: hit, miss with replay, uncached write, back-to-back
        run_store(2'b01, 3'd3, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF, 0, 1, 0, 1, 0, 1, 0, 3'd0, 0);
        run_store(2'b01, 3'd4, 32'h0000_1234, 32'h1234_5678, 4'hC, 1, 0, 1, 5, 0, 1, 0, 3'd0, 0);
        run_store(2'b00, 3'd5, 32'h1FE0_01E0, 32'hCAFE_F00D, 4'b0011, 0, 0, 0, 1, 3, 2, 0, 3'd0, 0);
        run_store(2'b01, 3'd1, 32'h0000_2468, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 1, 0, 1, 1, 3'd2, 0);
        run_store(2'b01, 3'd2, 32'h0000_2468, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 1, 0, 1, 0, 3'd0, 1);

        // Reset while waiting for a refill drops the store with no completion
        @(negedge Clk);
        bus.SbToDcdAble = 1; bus.SbToDcdAMat = 2'b01; bus.SbToDcdAPtr = 3'd6;
        bus.SbToDcdAPhyAddr = 32'h0000_5678; bus.SbToDcdAPhyDate = 32'h5555_AAAA;
        bus.SbToDcdAByteEn = 4'hF; bus.TagHit = 0;
        #1 check_eq("rst_accept", 32'(bus.DcdToSbSuccess), 1);
        @(negedge Clk); bus.SbToDcdAble = 0;
        #1 check_eq("rst_lookup", 32'(bus.TagRdEn), 1);
        @(negedge Clk); bus.TagHit = 0;
        @(negedge Clk);
        #1 check_eq("rst_missreq", 32'(bus.MissReq), 1);
        bus.MissAck = 1;
        @(negedge Clk); bus.MissAck = 0;
        #1 check_eq("rst_misswait_busy", 32'(bus.StorePortBusy), 1);
        check_eq("rst_misswait_req_low", 32'(bus.MissReq), 0);
        Rest = 1;
        @(negedge Clk); Rest = 0; bus.MissDone = 1;
        #1 check_eq("rst_mid_outs_zero", 32'(all_outs_zero()), 1);
        nback = 0;
        repeat (6) begin
            @(negedge Clk); bus.MissDone = 0;
            #1 if (bus.DcdToSbBackAble) nback++;
        end
        check_eq("rst_no_back", nback, 0);
        run_store(2'b01, 3'd7, 32'h0000_5678, 32'h5555_AAAA, 4'hF, 0, 1, 0, 1, 0, 1, 0, 3'd0, 0);

        // Random stores over both paths with random environment latencies
        for (int i = 0; i < 40; i++) begin
            logic [1:0] mat;
            if ($urandom_range(0, 1) == 1) mat = MAT_CC;
            else begin
                case ($urandom_range(0, 2))
                    0:       mat = MAT_SUC;
                    1:       mat = MAT_WUC;
                    default: mat = 2'b11;
                endcase
            end
            run_store(mat, 3'($urandom_range(1, 7)), $urandom, $urandom, 4'($urandom_range(1, 15)),
                      $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 3),
                      $urandom_range(1, 5), $urandom_range(0, 4), $urandom_range(1, 4),
                      0, 3'd0, 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
